// File: rtl/jtkiwi_pkg.sv
// Shared constants, state type and helpers for the jtkiwi line buffer.
// Holds the default widths, the erase value and the transparency test.
package jtkiwi_pkg;

    localparam int         LBUF_DW    = 9;
    localparam int         LBUF_AW    = 9;
    localparam int         LBUF_BLANK = 0;
    localparam logic [3:0] LBUF_TMASK = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CHK  = 1'b1
    } lbuf_st_e;

    // A pixel whose low nibble is zero is see-through.
    function automatic logic lbuf_transp(input logic [3:0] pxl);
        return (pxl & LBUF_TMASK) == 4'h0;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port line RAM: synchronous writes, combinational reads.
// Ports: clk; port A addr_a/data_a/we_a/q_a; port B addr_b/data_b/we_b/q_b.
module jtframe_dual_ram #(
    parameter int DW = 9,
    parameter int AW = 9
)(
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] data_a,
    input  logic          we_a,
    output logic [DW-1:0] q_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_b,
    input  logic          we_b,
    output logic [DW-1:0] q_b
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Reads return the pre-write contents, so the display port can
    // fetch a pixel and erase it in the same cycle.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
    end

    assign q_a = mem[addr_a];
    assign q_b = mem[addr_b];

endmodule

// File: rtl/jtkiwi_lbuf.sv
// Double-banked sprite line buffer: renderer fills one bank while the
// other is shown and erased pixel by pixel; banks swap on LHBL fall.
// Ports: clk, rst (sync, active high), pxl_cen, LHBL (active low),
//   hdump (display column), wr_addr/wr_data/wr_we/wr_rdy (renderer),
//   col_addr (pixel to the colour mixer).
// Macro JTKIWI_LBUF_PRIO_EN: first-writer-wins read-modify-write,
//   two clocks per write; without it every opaque write lands at once.
module jtkiwi_lbuf
    import jtkiwi_pkg::*;
#(
    parameter int DW    = LBUF_DW,
    parameter int AW    = LBUF_AW,
    parameter int BLANK = LBUF_BLANK
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic [8:0]    hdump,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_we,
    output logic          wr_rdy,
    output logic [DW-1:0] col_addr
);

    localparam logic [DW-1:0] BLANK_W = DW'(BLANK);

    logic          rd_bank_q, rd_bank_d;
    logic          lhbl_q,    lhbl_d;
    logic [DW-1:0] col_addr_q, col_addr_d;

    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_bank;
    logic          a_we;
    logic [1:0]    we_a, we_b;
    logic [DW-1:0] q_a [2];
    logic [DW-1:0] q_b [2];
    logic          unused_q;

    assign rd_addr = AW'(hdump);
    assign rd_en   = pxl_cen & LHBL & ~rst;

    assign we_a = {a_we & a_bank, a_we & ~a_bank};
    assign we_b = {rd_en & rd_bank_q, rd_en & ~rd_bank_q};

    for (genvar i = 0; i < 2; i++) begin : g_bank
        jtframe_dual_ram #(
            .DW (DW),
            .AW (AW)
        ) u_ram (
            .clk    (clk),
            .addr_a (a_addr),
            .data_a (a_data),
            .we_a   (we_a[i]),
            .q_a    (q_a[i]),
            .addr_b (rd_addr),
            .data_b (BLANK_W),
            .we_b   (we_b[i]),
            .q_b    (q_b[i])
        );
    end

    // Port A read data only matters to the priority check.
    assign unused_q = ^{q_a[0], q_a[1]};

    always_comb begin
        lhbl_d     = LHBL;
        rd_bank_d  = rd_bank_q ^ (lhbl_q & ~LHBL);
        col_addr_d = col_addr_q;
        if (pxl_cen) begin
            col_addr_d = LHBL ? q_b[rd_bank_q] : BLANK_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank_q  <= 1'b0;
            lhbl_q     <= 1'b1;
            col_addr_q <= BLANK_W;
        end else begin
            rd_bank_q  <= rd_bank_d;
            lhbl_q     <= lhbl_d;
            col_addr_q <= col_addr_d;
        end
    end

    assign col_addr = col_addr_q;

`ifdef JTKIWI_LBUF_PRIO_EN
    lbuf_st_e      st_q, st_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          wb_q, wb_d;
    logic [DW-1:0] q_sel;

    assign q_sel = q_a[wb_q];

    // The destination bank is latched with the request, so a check
    // that straddles a swap still lands where it was aimed.
    always_comb begin
        st_d   = st_q;
        wa_d   = wa_q;
        wd_d   = wd_q;
        wb_d   = wb_q;
        a_addr = wa_q;
        a_data = wd_q;
        a_bank = wb_q;
        a_we   = 1'b0;
        wr_rdy = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                wr_rdy = 1'b1;
                if (wr_we && !lbuf_transp(wr_data[3:0])) begin
                    wr_rdy = 1'b0;
                    wa_d   = wr_addr;
                    wd_d   = wr_data;
                    wb_d   = ~rd_bank_q;
                    st_d   = ST_CHK;
                end
            end
            ST_CHK: begin
                a_we   = lbuf_transp(q_sel[3:0]);
                wr_rdy = 1'b1;
                st_d   = ST_IDLE;
            end
        endcase
        if (rst) begin
            a_we   = 1'b0;
            wr_rdy = 1'b0;
            st_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) st_q <= ST_IDLE;
        else     st_q <= st_d;
    end

    always_ff @(posedge clk) begin
        wa_q <= wa_d;
        wd_q <= wd_d;
        wb_q <= wb_d;
    end
`else
    always_comb begin
        a_addr = wr_addr;
        a_data = wr_data;
        a_bank = ~rd_bank_q;
        a_we   = wr_we & ~rst & ~lbuf_transp(wr_data[3:0]);
        wr_rdy = ~rst;
    end
`endif

endmodule
